// File: rtl/shift_arbiter.sv
// Two-port round-robin front end for a shared 8-bit left rotate/shift unit.
// Results land in a single-entry output register tagged with the source port.
module shift_arbiter #(
  parameter int W  = 8,
  parameter int SW = 3,
  parameter int CW = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          A_VALID,
  input  logic [W-1:0]  A_I,
  input  logic [SW-1:0] A_S,
  input  logic          A_P,
  output logic          A_READY,
  input  logic          B_VALID,
  input  logic [W-1:0]  B_I,
  input  logic [SW-1:0] B_S,
  input  logic          B_P,
  output logic          B_READY,
  output logic          O_VALID,
  output logic [W-1:0]  O,
  output logic          O_TAG,
  input  logic          O_READY,
  output logic [CW-1:0] CNT_A,
  output logic [CW-1:0] CNT_B
);

  // Handshake: a transfer on any port happens in a cycle where VALID and
  // READY are both high at the rising edge. READY may depend on VALID, and
  // no transfer completes while RST is high.

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state_q;
  logic            last_grant_q;   // 0 = A, 1 = B
  logic [W-1:0]    o_q;
  logic            tag_q;
  logic [CW-1:0]   cnt_a_q;
  logic [CW-1:0]   cnt_b_q;

  logic            can_accept;
  logic            grant_b;
  logic            accept;
  logic [W-1:0]    sel_i;
  logic [SW-1:0]   sel_s;
  logic            sel_p;
  logic [2*W-1:0]  dbl;
  logic [W-1:0]    result_d;

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  assign can_accept = (state_q == EMPTY) | O_READY;

  // On a tie, grant the port that did not win the last accept.
  always_comb begin
    grant_b = 1'b0;
    if (A_VALID && B_VALID) grant_b = ~last_grant_q;
    else if (B_VALID)       grant_b = 1'b1;
  end

  assign A_READY = ~RST & can_accept & A_VALID & ~grant_b;
  assign B_READY = ~RST & can_accept & B_VALID &  grant_b;
  assign accept  = A_READY | B_READY;

  always_comb begin
    sel_i = grant_b ? B_I : A_I;
    sel_s = grant_b ? B_S : A_S;
    sel_p = grant_b ? B_P : A_P;
  end

  // Rotation falls out of shifting a doubled operand and keeping the top half.
  always_comb begin
    dbl      = {sel_i, sel_i} << sel_s;
    result_d = sel_p ? dbl[2*W-1:W] : (sel_i << sel_s);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= EMPTY;
      last_grant_q <= 1'b1;
      o_q          <= '0;
      tag_q        <= 1'b0;
      cnt_a_q      <= '0;
      cnt_b_q      <= '0;
    end else begin
      case (state_q)
        EMPTY: if (accept) state_q <= FULL;
        FULL:  if (O_READY && !accept) state_q <= EMPTY;
        default: state_q <= EMPTY;
      endcase
      if (accept) begin
        o_q          <= result_d;
        tag_q        <= grant_b;
        last_grant_q <= grant_b;
      end
      if (A_READY && cnt_a_q != CNT_MAX) cnt_a_q <= cnt_a_q + 1'b1;
      if (B_READY && cnt_b_q != CNT_MAX) cnt_b_q <= cnt_b_q + 1'b1;
    end
  end

  assign O_VALID = (state_q == FULL);
  assign O       = o_q;
  assign O_TAG   = tag_q;
  assign CNT_A   = cnt_a_q;
  assign CNT_B   = cnt_b_q;

endmodule
